// File: rtl/chess_disp_pkg.sv
// ----------------------------------------------------------------------------
// chess_disp_pkg : segment patterns, countdown field slices, digit indices
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package chess_disp_pkg;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam int MIN_MSB  = 9;
    localparam int MIN_LSB  = 7;
    localparam int SEC1_MSB = 6;
    localparam int SEC1_LSB = 4;
    localparam int SEC2_MSB = 3;
    localparam int SEC2_LSB = 0;

    localparam logic [2:0] IDX_B_SEC2 = 3'd0;
    localparam logic [2:0] IDX_B_SEC1 = 3'd1;
    localparam logic [2:0] IDX_B_MIN  = 3'd2;
    localparam logic [2:0] IDX_B_MARK = 3'd3;
    localparam logic [2:0] IDX_W_SEC2 = 3'd4;
    localparam logic [2:0] IDX_W_SEC1 = 3'd5;
    localparam logic [2:0] IDX_W_MIN  = 3'd6;
    localparam logic [2:0] IDX_W_MARK = 3'd7;

endpackage

`default_nettype wire

// File: rtl/seg7_decode.sv
// ----------------------------------------------------------------------------
// seg7_decode : 4-bit value plus blank/error/dash selects to active-low segments
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module seg7_decode
    import chess_disp_pkg::*;
(
    input  logic [3:0] i_val,
    input  logic       i_blank,
    input  logic       i_err,
    input  logic       i_dash,
    output logic [6:0] o_seg
);

    // Priority: blank over error over dash over numeric value
    always_comb begin
        o_seg = SEG_BLANK;
        if (i_blank) begin
            o_seg = SEG_BLANK;
        end else if (i_err) begin
            o_seg = SEG_E;
        end else if (i_dash) begin
            o_seg = SEG_DASH;
        end else begin
            case (i_val)
                4'd0:    o_seg = SEG_0;
                4'd1:    o_seg = SEG_1;
                4'd2:    o_seg = SEG_2;
                4'd3:    o_seg = SEG_3;
                4'd4:    o_seg = SEG_4;
                4'd5:    o_seg = SEG_5;
                4'd6:    o_seg = SEG_6;
                4'd7:    o_seg = SEG_7;
                4'd8:    o_seg = SEG_8;
                4'd9:    o_seg = SEG_9;
                default: o_seg = SEG_E;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/chess_clock_display.sv
// ----------------------------------------------------------------------------
// chess_clock_display : 8-digit multiplexed display of both chess countdowns.
// Optional macro LOW_TIME_FLASH_EN flashes the side-to-move's time under 10 s.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module chess_clock_display
    import chess_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] countdownWhite,
    input  logic [9:0] countdownBlack,
    input  logic       side,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int BW = $clog2(BLINK_DIV);
    localparam logic [PW-1:0] REF_LAST   = PW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [PW-1:0] r_presc;
    logic [BW-1:0] r_blink_cnt;
    logic          r_blink_phase;
    logic [2:0]    r_idx;
    logic [9:0]    r_snap_w;
    logic [9:0]    r_snap_b;
    logic          r_snap_side;

    logic       w_tick;
    logic       w_fallen;
    logic       w_white_half;
    logic [9:0] w_cd;
    logic       w_low_blank;
    logic [3:0] w_val;
    logic       w_blank;
    logic       w_err;
    logic       w_dash;
    logic       w_dp;
    logic [7:0] w_an;
    logic [6:0] w_seg;

    assign w_tick = (r_presc == REF_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc       <= '0;
            r_idx         <= '0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_snap_w      <= '0;
            r_snap_b      <= '0;
            r_snap_side   <= 1'b0;
        end else begin
            if (w_tick) begin
                r_presc <= '0;
                r_idx   <= r_idx + 3'd1;
                // Frame boundary: latch a coherent copy so a frame never tears
                if (r_idx == IDX_W_MARK) begin
                    r_snap_w    <= countdownWhite;
                    r_snap_b    <= countdownBlack;
                    r_snap_side <= side;
                end
            end else begin
                r_presc <= r_presc + 1'b1;
            end
            if (r_blink_cnt == BLINK_LAST) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    assign w_fallen     = (r_snap_w == 10'd0) && (r_snap_b == 10'd0);
    assign w_white_half = r_idx[2];
    assign w_cd         = w_white_half ? r_snap_w : r_snap_b;

`ifdef LOW_TIME_FLASH_EN
    logic [9:0] w_mover_cd;
    logic       w_low_time;
    assign w_mover_cd  = r_snap_side ? r_snap_b : r_snap_w;
    assign w_low_time  = (w_mover_cd[MIN_MSB:MIN_LSB] == 3'd0) &&
                         (w_mover_cd[SEC1_MSB:SEC1_LSB] == 3'd0) &&
                         (w_mover_cd != 10'd0);
    assign w_low_blank = w_low_time && r_blink_phase && (w_white_half == ~r_snap_side);
`else
    assign w_low_blank = 1'b0;
`endif

    always_comb begin
        w_val   = 4'd0;
        w_blank = 1'b0;
        w_err   = 1'b0;
        w_dash  = 1'b0;
        w_dp    = 1'b1;
        w_an    = ~(8'b0000_0001 << r_idx);
        case (r_idx[1:0])
            2'd3: begin
                w_dash  = (r_snap_side == ~w_white_half);
                w_blank = ~w_dash;
            end
            2'd2: begin
                w_val   = {1'b0, w_cd[MIN_MSB:MIN_LSB]};
                w_blank = w_low_blank;
                w_dp    = w_low_blank;
            end
            2'd1: begin
                w_val   = {1'b0, w_cd[SEC1_MSB:SEC1_LSB]};
                w_err   = (w_cd[SEC1_MSB:SEC1_LSB] > 3'd5);
                w_blank = w_low_blank;
            end
            default: begin
                w_val   = w_cd[SEC2_MSB:SEC2_LSB];
                w_err   = (w_cd[SEC2_MSB:SEC2_LSB] > 4'd9);
                w_blank = w_low_blank;
            end
        endcase
        if (w_fallen && r_blink_phase) begin
            w_an    = 8'hFF;
            w_blank = 1'b1;
            w_dp    = 1'b1;
        end
    end

    seg7_decode u_dec (
        .i_val   (w_val),
        .i_blank (w_blank),
        .i_err   (w_err),
        .i_dash  (w_dash),
        .o_seg   (w_seg)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= 8'hFF;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an  <= w_an;
            seg <= w_seg;
            dp  <= w_dp;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_chess_clock_display.sv
// ----------------------------------------------------------------------------
// tb_chess_clock_display : directed checks of chess_clock_display
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_chess_clock_display;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SD = 7'b0111111;
    localparam logic [6:0] SE = 7'b0000110;
    localparam logic [6:0] SB = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] cw  = 10'd0;
    logic [9:0] cb  = 10'd0;
    logic       side = 1'b0;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;

    int k      = 0;
    int total  = 0;
    int passed = 0;
    int failed = 0;

    chess_clock_display #(
        .REFRESH_DIV (4),
        .BLINK_DIV   (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .countdownWhite (cw),
        .countdownBlack (cb),
        .side           (side),
        .an             (an),
        .seg            (seg),
        .dp             (dp)
    );

    always #5 clk = ~clk;

    // k counts posedges since reset release; sampling happens on negedges
    task automatic adv_to(input int tgt);
        while (k < tgt) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] ean,
                       input logic [6:0] eseg, input logic edp);
        total++;
        assert (an === ean && seg === eseg && dp === edp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s (k=%0d): an=%h seg=%b dp=%b, expected an=%h seg=%b dp=%b",
                   tag, k, an, seg, dp, ean, eseg, edp);
        end
    endtask

    // Output at posedge k shows digit floor((k-1)/4) mod 8
    task automatic slot(input string tag, input int kk, input int idx,
                        input logic [6:0] eseg, input logic edp);
        logic [7:0] ean;
        ean = ~(8'b0000_0001 << idx);
        adv_to(kk);
        chk(tag, ean, eseg, edp);
    endtask

    initial begin
        cw   = 10'b100_101_1001;
        cb   = 10'b011_000_0111;
        side = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset", 8'hFF, 7'h7F, 1'b1);
        rst = 1'b0;
        k   = 0;

        // Reset snapshot is all zeros: fallen flag, phase 0 shows 0.00
        slot("rst_snap_idx0", 1, 0, S0, 1'b1);
        slot("rst_snap_idx2", 9, 2, S0, 1'b0);
        slot("rst_snap_idx3", 13, 3, SB, 1'b1);
        adv_to(17);
        chk("rst_snap_blank", 8'hFF, SB, 1'b1);

        // Frame 2 shows the latched inputs
        slot("f2_idx0", 33, 0, S7, 1'b1);
        slot("f2_idx1", 37, 1, S0, 1'b1);
        adv_to(40);
        cw = 10'b100_101_1000;
        slot("f2_idx2", 41, 2, S3, 1'b0);
        slot("f2_idx2_end", 44, 2, S3, 1'b0);
        slot("f2_idx3", 45, 3, SB, 1'b1);
        slot("f2_idx4_old", 49, 4, S9, 1'b1);
        slot("f2_idx5", 53, 5, S5, 1'b1);
        slot("f2_idx6", 57, 6, S4, 1'b0);
        slot("f2_idx7", 61, 7, SD, 1'b1);
        slot("f2_idx7_end", 64, 7, SD, 1'b1);
        slot("f3_idx4_new", 81, 4, S8, 1'b1);

        // Malformed BCD fields
        cw = 10'b100_101_1100;
        cb = 10'b011_110_0111;
        slot("err_idx0", 97, 0, S7, 1'b1);
        slot("err_idx1", 101, 1, SE, 1'b1);
        slot("err_idx2", 105, 2, S3, 1'b0);
        slot("err_idx3", 109, 3, SB, 1'b1);
        slot("err_idx4", 113, 4, SE, 1'b1);
        slot("err_idx5", 117, 5, S5, 1'b1);
        slot("err_idx6", 121, 6, S4, 1'b0);
        slot("err_idx7", 125, 7, SD, 1'b1);

        // Flag fallen: phase 0 covers k=129..144, phase 1 covers k=145..160
        cw = 10'd0;
        cb = 10'd0;
        slot("fall_idx0", 129, 0, S0, 1'b1);
        slot("fall_idx2", 137, 2, S0, 1'b0);
        slot("fall_idx3", 141, 3, SB, 1'b1);
        for (int i = 145; i <= 150; i++) begin
            adv_to(i);
            chk("fall_blank", 8'hFF, SB, 1'b1);
        end

        // Reset mid-frame
        rst = 1'b1;
        @(negedge clk);
        chk("midreset", 8'hFF, 7'h7F, 1'b1);
        rst = 1'b0;
        k   = 0;
        slot("restart_idx0", 4, 0, S0, 1'b1);
        slot("restart_idx1", 5, 1, S0, 1'b1);

        // White to move with 5 s left; White digits fall in blink phase 1
        cw   = 10'b000_000_0101;
        cb   = 10'b011_000_0111;
        side = 1'b0;
        slot("lt_idx2", 41, 2, S3, 1'b0);
        slot("lt_idx3", 45, 3, SB, 1'b1);
`ifdef LOW_TIME_FLASH_EN
        slot("lt_idx4", 49, 4, SB, 1'b1);
        slot("lt_idx5", 53, 5, SB, 1'b1);
        slot("lt_idx6", 57, 6, SB, 1'b1);
`else
        slot("lt_idx4", 49, 4, S5, 1'b1);
        slot("lt_idx5", 53, 5, S0, 1'b1);
        slot("lt_idx6", 57, 6, S0, 1'b0);
`endif
        slot("lt_idx7", 61, 7, SD, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
